// File: rtl/multiexp_g2_kernel_rd_burst_gen.sv
// rtl/multiexp_g2_kernel_rd_burst_gen.sv - AXI4 read-address burst generator with outstanding-credit throttle
// Optional AR back-pressure counter enabled by defining MULTIEXP_G2_RD_STALL_CNT_EN.
module multiexp_g2_kernel_rd_burst_gen #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_XFER_BYTES      = 64,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [C_ADDR_WIDTH-1:0]                addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0]              xfer_size_bytes,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   arvalid,
  input  logic                                   arready,
  output logic [C_ADDR_WIDTH-1:0]                araddr,
  output logic [7:0]                             arlen,
  input  logic                                   burst_done,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [31:0]                            stall_cycles
);

  localparam int BURST_BYTES = C_BURST_LEN * C_XFER_BYTES;
  localparam int XFER_SHIFT  = $clog2(C_XFER_BYTES);
  localparam int LEN_SHIFT   = $clog2(C_BURST_LEN);
  localparam int OW          = $clog2(C_MAX_OUTSTANDING + 1);
  // One extra bit keeps the round-up additions overflow-free for a full-scale size.
  localparam int CW          = C_LENGTH_WIDTH + 1;

  localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK = ~(C_ADDR_WIDTH'(BURST_BYTES - 1));
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP  = C_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [7:0]              TAIL_MASK  = 8'(C_BURST_LEN - 1);
  localparam logic [7:0]              FULL_LEN   = 8'(C_BURST_LEN - 1);
  localparam logic [OW-1:0]           MAX_OSD    = OW'(C_MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      state_q;
  logic [C_ADDR_WIDTH-1:0]     addr_q;
  logic [C_LENGTH_WIDTH-1:0]   size_q;
  logic [CW-1:0]               left_q;
  logic [7:0]                  tail_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        arvalid_q;
  logic [C_ADDR_WIDTH-1:0]     araddr_q;
  logic [7:0]                  arlen_q;
  logic [OW-1:0]               osd_q;

  logic [CW-1:0]               beats_w;
  logic [CW-1:0]               bursts_w;
  logic [7:0]                  tail_w;
  logic                        hs;
  logic                        bd;
  logic [OW-1:0]               osd_d;
  logic [CW-1:0]               left_d;
  logic [C_ADDR_WIDTH-1:0]     addr_d;
  logic                        can_issue;
  logic [7:0]                  len_d;

  assign beats_w  = ({1'b0, size_q} + CW'(C_XFER_BYTES - 1)) >> XFER_SHIFT;
  assign bursts_w = (beats_w + CW'(C_BURST_LEN - 1)) >> LEN_SHIFT;
  assign tail_w   = beats_w[7:0] & TAIL_MASK;

  assign hs = arvalid_q & arready;
  assign bd = burst_done & (osd_q != '0);

  always_comb begin
    osd_d = osd_q;
    if (hs && !bd) begin
      osd_d = osd_q + OW'(1);
    end else if (!hs && bd) begin
      osd_d = osd_q - OW'(1);
    end
  end

  // Next burst to present, looking through a handshake in this cycle so
  // back-to-back bursts keep arvalid asserted without a bubble.
  always_comb begin
    left_d    = hs ? (left_q - CW'(1)) : left_q;
    addr_d    = hs ? (addr_q + ADDR_STEP) : addr_q;
    can_issue = (left_d != '0) && (osd_d < MAX_OSD);
    len_d     = ((left_d == CW'(1)) && (tail_q != 8'd0)) ? (tail_q - 8'd1) : FULL_LEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      left_q    <= '0;
      tail_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      osd_q     <= '0;
    end else begin
      osd_q  <= osd_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr_offset & ALIGN_MASK;
            size_q  <= xfer_size_bytes;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          left_q <= bursts_w;
          tail_q <= tail_w;
          if (bursts_w == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!arvalid_q || hs) begin
            arvalid_q <= can_issue;
            if (can_issue) begin
              araddr_q <= addr_d;
              arlen_q  <= len_d;
            end
          end
          if (hs) begin
            addr_q <= addr_d;
            left_q <= left_d;
            if (left_d == '0) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (osd_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MULTIEXP_G2_RD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (arvalid_q && !arready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign arvalid     = arvalid_q;
  assign araddr      = araddr_q;
  assign arlen       = arlen_q;
  assign outstanding = osd_q;

endmodule

// File: tb/tb_multiexp_g2_kernel_rd_burst_gen.sv
// tb/tb_multiexp_g2_kernel_rd_burst_gen.sv - scoreboard bench for the AR burst generator
// Built with C_MAX_OUTSTANDING=4; stall expectation follows MULTIEXP_G2_RD_STALL_CNT_EN.
module tb_multiexp_g2_kernel_rd_burst_gen;

  localparam int XB   = 64;
  localparam int BL   = 64;
  localparam int BB   = XB * BL;
  localparam int MAXO = 4;
`ifdef MULTIEXP_G2_RD_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] addr_offset;
  logic [31:0] xfer_size_bytes;
  logic        busy;
  logic        done;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic        burst_done;
  logic [2:0]  outstanding;
  logic [31:0] stall_cycles;

  multiexp_g2_kernel_rd_burst_gen #(
    .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_offset(addr_offset),
    .xfer_size_bytes(xfer_size_bytes), .busy(busy), .done(done), .arvalid(arvalid),
    .arready(arready), .araddr(araddr), .arlen(arlen), .burst_done(burst_done),
    .outstanding(outstanding), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_ar[$];
  int          due_q[$];
  int          pending_done = 0;
  int          exp_osd = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          rdy_mode = 0;
  bit          manual_rdy = 1'b0;
  bit          manual_bd = 1'b0;
  bit          auto_resp = 1'b1;
  bit          rand_resp = 1'b0;
  bit          prev_wait = 1'b0;
  bit          busy_chk = 1'b0;
  logic [63:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_busy"}, 64'(busy), 64'd0);
    chk_eq({tag, "_done"}, 64'(done), 64'd0);
    chk_eq({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    chk_eq({tag, "_araddr"}, araddr, 64'd0);
    chk_eq({tag, "_arlen"}, 64'(arlen), 64'd0);
    chk_eq({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    chk_eq({tag, "_stall"}, 64'(stall_cycles), 64'd0);
  endtask

  // Reference: aligned base, ceil-divided beats/bursts, shortened tail burst.
  task automatic model_req(input logic [63:0] a, input logic [31:0] s, input longint limit);
    logic [63:0] base, beats, nb, tail;
    ar_t e;
    base  = a & ~64'(BB - 1);
    beats = ({32'd0, s} + 64'(XB - 1)) / XB;
    nb    = (beats + 64'(BL - 1)) / BL;
    tail  = beats % BL;
    for (longint i = 0; i < longint'(nb) && i < limit; i++) begin
      e.addr = base + 64'(i) * BB;
      e.len  = ((64'(i) == nb - 1) && (tail != 0)) ? 8'(tail - 1) : 8'(BL - 1);
      exp_ar.push_back(e);
    end
    pending_done++;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    case (rdy_mode)
      0:       arready = 1'b1;
      1:       arready = ($urandom_range(0, 3) != 0);
      default: arready = manual_rdy;
    endcase
    if (!rst_n) begin
      due_q.delete();
      burst_done = 1'b0;
    end else if (!auto_resp) begin
      burst_done = manual_bd;
      if (manual_bd && due_q.size() > 0) void'(due_q.pop_front());
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      burst_done = 1'b1;
      void'(due_q.pop_front());
    end else begin
      burst_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ar.delete();
      pending_done = 0;
      exp_osd      = 0;
      prev_wait    = 1'b0;
      busy_chk     = 1'b0;
    end else begin
      ar_t e;
      bit  hs;
      hs = arvalid && arready;
      chk_eq("outstanding", 64'(outstanding), 64'(exp_osd));
      if (busy_chk) begin
        chk_eq("busy_after_done", 64'(busy), 64'd0);
        busy_chk = 1'b0;
      end
      if (prev_wait) begin
        chk_eq("ar_valid_held", 64'(arvalid), 64'd1);
        chk_eq("ar_addr_stable", araddr, prev_addr);
        chk_eq("ar_len_stable", 64'(arlen), 64'(prev_len));
      end
      if (hs) begin
        hs_count++;
        chk_eq("ar_pending", 64'(exp_ar.size() > 0), 64'd1);
        if (exp_ar.size() > 0) begin
          e = exp_ar.pop_front();
          chk_eq("ar_addr", araddr, e.addr);
          chk_eq("ar_len", 64'(arlen), 64'(e.len));
        end
        due_q.push_back(cyc + (rand_resp ? int'($urandom_range(1, 8)) : 4));
      end
      if (done) begin
        chk_eq("done_expected", 64'(pending_done > 0), 64'd1);
        chk_eq("done_all_ars", 64'(exp_ar.size()), 64'd0);
        chk_eq("done_busy", 64'(busy), 64'd1);
        if (pending_done > 0) pending_done--;
        busy_chk = 1'b1;
      end
      exp_osd   = exp_osd + (hs ? 1 : 0) - ((burst_done && exp_osd > 0) ? 1 : 0);
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
    end
  end

  task automatic do_req(input logic [63:0] a, input logic [31:0] s, input int mode,
                        input bit stray, input longint limit);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk_eq("req_idle_wait", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b1; addr_offset = a; xfer_size_bytes = s;
    model_req(a, s, limit);
    @(posedge clk); #1;
    if (stray) begin
      addr_offset = {$urandom, $urandom};
      xfer_size_bytes = $urandom_range(1, 9000);
    end else begin
      start = 1'b0;
    end
    if (mode == 1) begin
      @(negedge clk);
      chk_eq("lat_busy", 64'(busy), 64'd1);
      chk_eq("lat_arvalid_e0", 64'(arvalid), 64'd0);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk_eq("lat_arvalid_e1", 64'(arvalid), 64'd0);
      @(negedge clk);
      chk_eq("lat_arvalid_e2", 64'(arvalid), 64'd1);
    end else if (mode == 2) begin
      @(negedge clk);
      chk_eq("zero_done_e0", 64'(done), 64'd0);
      chk_eq("zero_busy_e0", 64'(busy), 64'd1);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk_eq("zero_done_e1", 64'(done), 64'd1);
      chk_eq("zero_arvalid", 64'(arvalid), 64'd0);
    end else begin
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pending_done == 0 && !busy) break;
    end
    chk_eq("idle_reached", 64'(pending_done == 0 && !busy), 64'd1);
  endtask

  task automatic pulse_bd();
    @(negedge clk); manual_bd = 1'b1;
    @(negedge clk); manual_bd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_hs;
    int i;
    start = 1'b0; addr_offset = '0; xfer_size_bytes = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #3; rst_n = 1'b1;

    do_req(64'h1000, 32'd8192, 1, 1'b0, 64'd1 << 40);
    wait_idle(2000);
    chk_eq("stall_no_backpressure", 64'(stall_cycles), 64'd0);

    do_req(64'h1234, 32'd100, 0, 1'b0, 64'd1 << 40);
    wait_idle(2000);

    do_req(64'hABC0, 32'd0, 2, 1'b1, 64'd1 << 40);
    wait_idle(2000);

    auto_resp = 1'b0;
    pulse_bd();
    repeat (2) @(negedge clk);
    chk_eq("idle_bd_ignored", 64'(outstanding), 64'd0);

    base_hs = hs_count;
    do_req(64'h0, 32'd65536, 0, 1'b0, 64'd1 << 40);
    repeat (30) @(negedge clk);
    chk_eq("max_arvalid_low", 64'(arvalid), 64'd0);
    chk_eq("max_outstanding", 64'(outstanding), 64'(MAXO));
    chk_eq("max_ar_count", 64'(hs_count - base_hs), 64'(MAXO));
    pulse_bd();
    repeat (10) @(negedge clk);
    chk_eq("credit_one_more_ar", 64'(hs_count - base_hs), 64'(MAXO + 1));
    chk_eq("credit_arvalid_low", 64'(arvalid), 64'd0);
    rdy_mode = 2; manual_rdy = 1'b0;
    pulse_bd();
    pulse_bd();
    repeat (4) @(negedge clk);
    chk_eq("pre_same_osd", 64'(outstanding), 64'd2);
    chk_eq("pre_same_arvalid", 64'(arvalid), 64'd1);
    manual_rdy = 1'b1; manual_bd = 1'b1;
    @(negedge clk);
    manual_rdy = 1'b0; manual_bd = 1'b0;
    @(negedge clk);
    chk_eq("same_cycle_osd", 64'(outstanding), 64'd2);
    auto_resp = 1'b1; rdy_mode = 0;
    wait_idle(3000);
    chk_eq("max_total_ars", 64'(hs_count - base_hs), 64'd16);

    rdy_mode = 2; manual_rdy = 1'b0;
    do_req(64'h1000, 32'd8192, 0, 1'b0, 64'd1 << 40);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arvalid) break;
    end
    chk_eq("stall_arvalid_seen", 64'(arvalid), 64'd1);
    repeat (9) @(negedge clk);
    manual_rdy = 1'b1;
    wait_idle(2000);
    chk_eq("stall_cycles", 64'(stall_cycles), STALL_EN ? 64'd10 : 64'd0);
    rdy_mode = 0;

    base_hs = hs_count;
    do_req(64'h0, 32'hFFFF_FFFF, 0, 1'b0, 64'd12);
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (hs_count - base_hs >= 6) break;
    end
    chk_eq("abort_ars_seen", 64'(hs_count - base_hs >= 6), 64'd1);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #3; rst_n = 1'b1;
    do_req(64'h2000_0040, 32'd5000, 1, 1'b0, 64'd1 << 40);
    wait_idle(2000);
    chk_eq("post_abort_stall", 64'(stall_cycles), 64'd0);

    rdy_mode = 1; rand_resp = 1'b1;
    for (int k = 0; k < 25; k++) begin
      logic [31:0] sz;
      case ($urandom_range(0, 4))
        0:       sz = 32'd0;
        1:       sz = $urandom_range(1, 64);
        2:       sz = $urandom_range(1, 4096);
        3:       sz = $urandom_range(4097, 20000);
        default: sz = $urandom_range(20001, 70000);
      endcase
      do_req({$urandom, $urandom}, sz, 0, 1'($urandom_range(0, 1)), 64'd1 << 40);
      wait_idle(4000);
    end
    rdy_mode = 0; rand_resp = 1'b0;
    repeat (20) @(negedge clk);
    chk_eq("final_no_pending_ar", 64'(exp_ar.size()), 64'd0);
    chk_eq("final_outstanding", 64'(outstanding), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
